// File: rtl/core_s1_s2_queue_if.sv
// Valid/ready handshake carrying one instruction (pc + instruction word).
// The producer of an entry uses the master modport, the consumer uses slave.
interface core_s1_s2_queue_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) ();
   logic               valid;
   logic               ready;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;

   modport master (output valid, output pc, output instr, input ready);
   modport slave  (input valid, input pc, input instr, output ready);
endinterface

// File: rtl/core_s1_s2_queue.sv
// DEPTH-entry decoupling FIFO between fetch (s1) and execute (s2), flushed by invalidate_fetch.
// Define CORE_S1_S2_QUEUE_BYPASS_EN for a zero-latency combinational path when the queue is empty.
module core_s1_s2_queue #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   core_s1_s2_queue_if.slave          s1,
   core_s1_s2_queue_if.master         s2,
   input  logic                       invalidate_fetch,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [31:0]                stall_cycles
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic              empty, full, bypass;
   logic              push, pop, store_push, store_pop;
   entry_t            head;

   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);

`ifdef CORE_S1_S2_QUEUE_BYPASS_EN
   assign bypass = empty && s1.valid && !invalidate_fetch;
`else
   assign bypass = 1'b0;
`endif

   // A full queue refuses a push even while the head is being popped.
   assign s1.ready = !full;
   assign push     = s1.valid && s1.ready;
   assign pop      = s2.valid && s2.ready;

   // A bypassed entry taken by s2 in the same cycle never touches storage.
   assign store_push = push && !(bypass && s2.ready);
   assign store_pop  = pop && !bypass;

   assign head      = mem[rd_ptr[IDX_W-1:0]];
   assign occupancy = wr_ptr - rd_ptr;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      s2.valid = !empty || bypass;
      s2.pc    = '0;
      s2.instr = '0;
      if (bypass) begin
         s2.pc    = s1.pc;
         s2.instr = s1.instr;
      end else if (!empty) begin
         s2.pc    = head.pc;
         s2.instr = head.instr;
      end
   end

   // NOTE: state registers update with non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (invalidate_fetch) begin
         // Any pop this cycle has already been seen by s2; the push is dropped.
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (store_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (store_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // NOTE: the entry array has no reset; the pointers alone define which slots hold live data.
   always_ff @(posedge clk) begin
      if (store_push && !invalidate_fetch) begin
         mem[wr_ptr[IDX_W-1:0]] <= '{pc: s1.pc, instr: s1.instr};
      end
   end

   // Survives flushes so fetch back-pressure can be measured across branches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (s1.valid && !s1.ready && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
endmodule

// File: tb/tb_core_s1_s2_queue.sv
// Self-checking bench for core_s1_s2_queue: vector table plus scoreboard of queued entries.
// Hand sequences cover back-to-back wrap, bypass/latency and mid-operation reset.
module tb_core_s1_s2_queue;
   localparam int DEPTH = 4;
`ifdef CORE_S1_S2_QUEUE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        invalidate_fetch;
   logic [2:0]  occupancy;
   logic [31:0] stall_cycles;

   core_s1_s2_queue_if #(.PC_W(32), .INSTR_W(32)) s1_bus ();
   core_s1_s2_queue_if #(.PC_W(32), .INSTR_W(32)) s2_bus ();

   core_s1_s2_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s1               (s1_bus.slave),
      .s2               (s2_bus.master),
      .invalidate_fetch (invalidate_fetch),
      .occupancy        (occupancy),
      .stall_cycles     (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        rdy;
      logic        fl;
      logic [2:0]  exp_occ;
      logic        exp_s1_ready;
   } vec_t;

   ent_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] stall_exp = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus at the falling edge, compare against the scoreboard,
   // then advance the scoreboard as the coming rising edge will.
   task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
      logic        bp, exp_valid, exp_ready, push, pop;
      logic [31:0] exp_pc, exp_instr;
      @(negedge clk);
      s1_bus.valid     = v;
      s1_bus.pc        = pc;
      s1_bus.instr     = instr_of(pc);
      s2_bus.ready     = rdy;
      invalidate_fetch = fl;
      #1;
      bp        = BYPASS && (sb.size() == 0) && v && !fl;
      exp_ready = (sb.size() < DEPTH);
      exp_valid = (sb.size() != 0) || bp;
      exp_pc    = 32'h0;
      exp_instr = 32'h0;
      if (sb.size() != 0) begin
         exp_pc    = sb[0].pc;
         exp_instr = sb[0].instr;
      end else if (bp) begin
         exp_pc    = pc;
         exp_instr = instr_of(pc);
      end
      check("s1_ready",     64'(s1_bus.ready), 64'(exp_ready));
      check("s2_valid",     64'(s2_bus.valid), 64'(exp_valid));
      check("s2_pc",        64'(s2_bus.pc),    64'(exp_pc));
      check("s2_instr",     64'(s2_bus.instr), 64'(exp_instr));
      check("occupancy",    64'(occupancy),    64'(sb.size()));
      check("stall_cycles", 64'(stall_cycles), 64'(stall_exp));
      push = v && exp_ready;
      pop  = exp_valid && rdy;
      if (pop && sb.size() != 0) void'(sb.pop_front());
      if (fl) sb.delete();
      else if (push && !(bp && rdy)) sb.push_back('{pc: pc, instr: instr_of(pc)});
      if (v && !exp_ready && stall_exp != 32'hFFFF_FFFF) stall_exp++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[20];
      vecs = '{
         // fill to full with s2 stalled, then hold s1_valid three more cycles
         '{1'b1, 32'h100, 1'b0, 1'b0, 3'd0, 1'b1},
         '{1'b1, 32'h104, 1'b0, 1'b0, 3'd1, 1'b1},
         '{1'b1, 32'h108, 1'b0, 1'b0, 3'd2, 1'b1},
         '{1'b1, 32'h10C, 1'b0, 1'b0, 3'd3, 1'b1},
         '{1'b1, 32'h110, 1'b0, 1'b0, 3'd4, 1'b0},
         '{1'b1, 32'h114, 1'b0, 1'b0, 3'd4, 1'b0},
         '{1'b1, 32'h118, 1'b0, 1'b0, 3'd4, 1'b0},
         // drain in order
         '{1'b0, 32'h0,   1'b1, 1'b0, 3'd4, 1'b0},
         '{1'b0, 32'h0,   1'b1, 1'b0, 3'd3, 1'b1},
         '{1'b0, 32'h0,   1'b1, 1'b0, 3'd2, 1'b1},
         '{1'b0, 32'h0,   1'b1, 1'b0, 3'd1, 1'b1},
         '{1'b0, 32'h0,   1'b0, 1'b0, 3'd0, 1'b1},
         // occupancy 3, flush with a push of 0x200 that must be dropped
         '{1'b1, 32'h180, 1'b0, 1'b0, 3'd0, 1'b1},
         '{1'b1, 32'h184, 1'b0, 1'b0, 3'd1, 1'b1},
         '{1'b1, 32'h188, 1'b0, 1'b0, 3'd2, 1'b1},
         '{1'b1, 32'h200, 1'b0, 1'b1, 3'd3, 1'b1},
         '{1'b0, 32'h0,   1'b1, 1'b0, 3'd0, 1'b1},
         // flush in the same cycle as a pop
         '{1'b1, 32'h1A0, 1'b0, 1'b0, 3'd0, 1'b1},
         '{1'b0, 32'h0,   1'b1, 1'b1, 3'd1, 1'b1},
         '{1'b0, 32'h0,   1'b0, 1'b0, 3'd0, 1'b1}
      };

      rst_n            = 1'b0;
      s1_bus.valid     = 1'b0;
      s1_bus.pc        = '0;
      s1_bus.instr     = '0;
      s2_bus.ready     = 1'b0;
      invalidate_fetch = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_s1_ready",  64'(s1_bus.ready), 64'd1);
      check("rst_s2_valid",  64'(s2_bus.valid), 64'd0);
      check("rst_occupancy", 64'(occupancy),    64'd0);
      check("rst_stall",     64'(stall_cycles), 64'd0);
      check("rst_s2_pc",     64'(s2_bus.pc),    64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         cycle(vecs[i].v, vecs[i].pc, vecs[i].rdy, vecs[i].fl);
         check($sformatf("vec%0d_occupancy", i), 64'(occupancy),    64'(vecs[i].exp_occ));
         check($sformatf("vec%0d_s1_ready", i),  64'(s1_bus.ready), 64'(vecs[i].exp_s1_ready));
         if (i == 7) check("stall_after_full", 64'(stall_cycles), 64'd3);
         if (i == 16) check("flush_s2_valid", 64'(s2_bus.valid), 64'd0);
      end

      // back-to-back push+pop across several pointer wraps
      cycle(1'b1, 32'h400, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0);
         check($sformatf("b2b%0d_occupancy", i), 64'(occupancy), 64'd1);
      end
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      check("b2b_drained", 64'(occupancy), 64'd0);

      // empty queue, push with s2 ready: bypass is same-cycle, otherwise one cycle later
      cycle(1'b1, 32'h300, 1'b1, 1'b0);
`ifdef CORE_S1_S2_QUEUE_BYPASS_EN
      check("bp_s2_valid", 64'(s2_bus.valid), 64'd1);
      check("bp_s2_pc",    64'(s2_bus.pc),    64'h300);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check("bp_occupancy", 64'(occupancy), 64'd0);
`else
      check("lat_s2_valid_n", 64'(s2_bus.valid), 64'd0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check("lat_s2_valid_n1", 64'(s2_bus.valid), 64'd1);
      check("lat_s2_pc_n1",    64'(s2_bus.pc),    64'h300);
`endif
      cycle(1'b0, 32'h0, 1'b0, 1'b0);

      // stall once more, then reset mid-operation with entries queued
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
      @(negedge clk);
      s1_bus.valid = 1'b0;
      rst_n        = 1'b0;
      #1;
      check("mid_rst_occupancy", 64'(occupancy),    64'd0);
      check("mid_rst_s2_valid",  64'(s2_bus.valid), 64'd0);
      check("mid_rst_s1_ready",  64'(s1_bus.ready), 64'd1);
      check("mid_rst_stall",     64'(stall_cycles), 64'd0);
      check("mid_rst_s2_pc",     64'(s2_bus.pc),    64'd0);
      sb.delete();
      stall_exp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 32'h600, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
